// File: rtl/eu_sequencer.sv
// eu_sequencer: runs one ALU instruction at a time as read A, read B,
// execute, optional write-back, then a completion pulse. The register
// memory and the ALU sit outside this block and are both combinational.
module eu_sequencer #(
    parameter int         DATA_W      = 8,
    parameter int         ADDR_W      = 5,
    parameter logic [3:0] NOWB_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    output logic              busy,
    output logic              done,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_flag,
    output logic [3:0]        flag_out,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] a1_q;
    logic [ADDR_W-1:0] a2_q;
    logic [ADDR_W-1:0] a3_q;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_op_q;

    // State register; reset wins over any start seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction latch, operand capture and result/flag capture. The
    // alu_*_q copies remember what was shown to the ALU so the ALU inputs
    // keep their last values once EXEC is over.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            a3_q     <= '0;
            opa      <= '0;
            opb      <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result   <= '0;
            flag_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= opcode;
                        a1_q <= addr1;
                        a2_q <= addr2;
                        a3_q <= addr3;
                    end
                end
                RD_A: opa <= mem_rdata;
                RD_B: opb <= mem_rdata;
                EXEC: begin
                    result   <= alu_out;
                    flag_out <= alu_flag;
                    alu_a_q  <= opa;
                    alu_b_q  <= opb;
                    alu_op_q <= op_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode plus every state-dependent output; memory defaults
    // to reading the first source address.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = a1_q;
        alu_a      = alu_a_q;
        alu_b      = alu_b_q;
        alu_opcode = alu_op_q;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = RD_A;
                end
            end
            RD_A: begin
                state_next = RD_B;
            end
            RD_B: begin
                mem_addr   = a2_q;
                state_next = EXEC;
            end
            EXEC: begin
                alu_a      = opa;
                alu_b      = opb;
                alu_opcode = op_q;
                state_next = (op_q == NOWB_OPCODE) ? DONE : WB;
            end
            WB: begin
                mem_rw     = 1'b1;
                mem_addr   = a3_q;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Write data is simply the last registered result.
    assign mem_wdata = result;

endmodule

// File: doc/eu_sequencer.md
EU_SEQUENCER -- requirements
Module: eu_sequencer

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 8, setting operand, result and memory data width.
REQ-002 The block SHALL have the parameter ADDR_W, default 5, setting register-memory address width (32 locations).
REQ-003 The block SHALL have the parameter NOWB_OPCODE, default 4'hF, naming the opcode that updates flags without write-back.
REQ-004 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: request one instruction; sampled only in IDLE.
REQ-007 The block SHALL have port opcode, input, 4 bits: ALU operation.
REQ-008 The block SHALL have ports addr1 and addr2, input, ADDR_W bits each: source operand addresses.
REQ-009 The block SHALL have port addr3, input, ADDR_W bits: destination address.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port mem_rw, output, 1 bit: 0 = read, 1 = write.
REQ-013 The block SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-014 The block SHALL have port mem_rdata, input, DATA_W bits: memory read data, combinationally valid in the same cycle as mem_addr.
REQ-015 The block SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-016 The block SHALL have port alu_opcode, output, 4 bits: ALU operation select.
REQ-017 The block SHALL have ports alu_a and alu_b, output, DATA_W bits each: ALU operands.
REQ-018 The block SHALL have port alu_out, input, DATA_W bits: combinational ALU result.
REQ-019 The block SHALL have port alu_flag, input, 4 bits: combinational ALU flags.
REQ-020 The block SHALL have port flag_out, output, 4 bits: registered flags from the last executed instruction.
REQ-021 The block SHALL have port result, output, DATA_W bits: registered result from the last executed instruction.

Function
REQ-022 The FSM SHALL have the states IDLE, RD_A, RD_B, EXEC, WB and DONE, one cycle each, all registered.
REQ-023 IDLE with start=1 at edge N SHALL latch opcode, addr1, addr2 and addr3 into internal registers and move to RD_A.
REQ-024 Input changes after the latch edge SHALL have no effect on the instruction in flight.
REQ-025 RD_A SHALL drive mem_addr=addr1 (latched) with mem_rw=0, capture mem_rdata into opA at the edge, and go to RD_B.
REQ-026 RD_B SHALL drive mem_addr=addr2 with mem_rw=0, capture mem_rdata into opB, and go to EXEC.
REQ-027 EXEC SHALL drive alu_a=opA, alu_b=opB and alu_opcode=latched opcode, then capture alu_out into result and alu_flag into flag_out.
REQ-028 From EXEC the FSM SHALL go to DONE if the opcode equals NOWB_OPCODE, otherwise to WB.
REQ-029 WB SHALL drive mem_rw=1, mem_addr=addr3 and mem_wdata=result for exactly one cycle, then go to DONE.
REQ-030 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-031 Latency from the start edge SHALL be: write at cycle N+4 and done at N+5 (N+4 for NOWB_OPCODE).
REQ-032 mem_rw SHALL be 1 only in WB; in every other state it SHALL be 0, and mem_addr SHALL be addr1 in IDLE.
REQ-033 start SHALL be ignored while busy=1 and SHALL NOT be queued.
REQ-034 start held high through DONE SHALL launch the next instruction from the IDLE cycle that follows, giving a 6-cycle issue interval.
REQ-035 addr1, addr2 and addr3 SHALL be allowed to be equal; operands are captured before write-back, so addr3=addr1 reads the old value.
REQ-036 alu_a, alu_b and alu_opcode SHALL hold their last values outside EXEC.
REQ-037 result and flag_out SHALL change only at the EXEC edge.
REQ-038 Arithmetic SHALL be defined by the ALU; the block SHALL pass DATA_W bits unmodified and SHALL NOT truncate or extend them.

Reset
REQ-039 rst=1 at any edge SHALL force IDLE, and SHALL force busy=0, done=0, mem_rw=0, mem_addr=0, mem_wdata=0, alu_a=0, alu_b=0, alu_opcode=0, result=0 and flag_out=0.
REQ-040 Reset asserted in any state, including WB, SHALL deassert mem_rw from the following cycle, and the in-flight instruction SHALL be dropped without a done pulse.
REQ-041 start sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-042 The bench SHALL cover this case: mem[3]=8'h12, mem[7]=8'h34, ADD opcode, addr1=3, addr2=7, addr3=9, start at N -> mem[9]=8'h46 written at N+4, done at N+5, flag_out per ALU.
REQ-043 The bench SHALL cover this case: opcode=NOWB_OPCODE, addr3=9, mem[9]=8'hAA -> mem[9] stays 8'hAA, flag_out updated, done at N+4, mem_rw never 1.
REQ-044 The bench SHALL cover this case: start pulsed again at N+2 during busy -> exactly one write and one done; second start ignored.
REQ-045 The bench SHALL cover this case: addr1=addr2=addr3=5, mem[5]=8'h10, ADD -> mem[5]=8'h20; operands equal the pre-write value.
REQ-046 The bench SHALL cover this case: rst at N+4 (WB cycle) -> busy=0, done never pulses, all outputs 0 at N+5, and the FSM accepts a fresh start at N+5.
REQ-047 The bench SHALL cover this case: start held high continuously -> instructions issue every 6 cycles, with done pulses exactly 6 cycles apart.
